// File: rtl/act_skew_feeder_if.sv
// rtl/act_skew_feeder_if.sv - activation vector input stream for act_skew_feeder
//
// Purpose: groups the vector valid/ready handshake into one bundle.
// Signals:
//   in_valid  master->slave  vector valid
//   in_ready  slave->master  feeder can accept a vector
//   in_data   master->slave  ROWS elements of WORDWIDTH+1 bits, element r at [r*(WORDWIDTH+1) +: WORDWIDTH+1]
//   in_last   master->slave  marks the final vector of a tile
interface act_skew_feeder_if #(
    parameter int WORDWIDTH = 8,
    parameter int ROWS      = 4
);
    logic                            in_valid;
    logic                            in_ready;
    logic [ROWS*(WORDWIDTH+1)-1:0]   in_data;
    logic                            in_last;

    modport master (output in_valid, output in_data, output in_last, input in_ready);
    modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/act_skew_feeder.sv
// rtl/act_skew_feeder.sv - skewed activation feeder and mode sequencer for a systolic array
//
// Purpose: buffers activation vectors in a FIFO, pops one per FEED cycle (zero
// bubble when empty) and delays row r by r extra registers so the array sees a
// diagonal wavefront. Sequences pe_mode: PS during FEED/DRAIN, WL in IDLE.
// Ports:
//   clk           rising-edge clock
//   reset_n       asynchronous active-low reset
//   in_if         slave side of the vector stream (valid/ready/data/last)
//   a_out         skewed activations, slice r drives row r
//   pe_mode       mode broadcast to all PEs
//   busy          high in FEED or DRAIN
//   done          one-cycle pulse when a tile finishes draining
//   bubble_count  (only with FEEDER_BUBBLE_COUNT_EN) saturating count of empty-FIFO FEED cycles
// Optional feature macro: FEEDER_BUBBLE_COUNT_EN
module act_skew_feeder #(
    parameter int WORDWIDTH  = 8,
    parameter int ROWS       = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    act_skew_feeder_if.slave              in_if,
`ifdef FEEDER_BUBBLE_COUNT_EN
    output logic [15:0]                   bubble_count,
`endif
    output logic [ROWS*(WORDWIDTH+1)-1:0] a_out,
    output logic                          pe_mode,
    output logic                          busy,
    output logic                          done
);
    localparam int  EW = WORDWIDTH + 1;
    localparam int  VW = ROWS * EW;
    localparam int  AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int  CW = $clog2(ROWS + 1);
    localparam logic PEMODE_WL = 1'b0;
    localparam logic PEMODE_PS = 1'b1;

    typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN} state_t;

    state_t          state_q, state_d;
    logic [VW-1:0]   mem_data_q [FIFO_DEPTH];
    logic [VW-1:0]   mem_data_d [FIFO_DEPTH];
    logic            mem_last_q [FIFO_DEPTH];
    logic            mem_last_d [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [CW-1:0]   drain_cnt_q, drain_cnt_d;
    logic            last_seen_q, last_seen_d;
    logic            in_ready_q, in_ready_d;
    logic            pe_mode_q, pe_mode_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
`ifdef FEEDER_BUBBLE_COUNT_EN
    logic [15:0]     bubble_q, bubble_d;
`endif

    logic            push, pop;
    logic [VW-1:0]   stage_in;

    always_comb begin
        push     = in_if.in_valid & in_ready_q;
        pop      = (state_q == S_FEED) && (count_q != '0);
        // Bubbles enter the same skew path as data, so rows carry zeros where nothing was popped.
        stage_in = pop ? mem_data_q[rd_ptr_q] : '0;

        state_d     = state_q;
        mem_data_d  = mem_data_q;
        mem_last_d  = mem_last_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        drain_cnt_d = drain_cnt_q;
        last_seen_d = last_seen_q;
        done_d      = 1'b0;
`ifdef FEEDER_BUBBLE_COUNT_EN
        bubble_d    = bubble_q;
`endif

        if (push) begin
            mem_data_d[wr_ptr_q] = in_if.in_data;
            mem_last_d[wr_ptr_q] = in_if.in_last;
            wr_ptr_d             = wr_ptr_q + AW'(1);
            if (in_if.in_last) last_seen_d = 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (push) begin
                    state_d  = S_FEED;
`ifdef FEEDER_BUBBLE_COUNT_EN
                    bubble_d = '0;
`endif
                end
            end
            S_FEED: begin
`ifdef FEEDER_BUBBLE_COUNT_EN
                if (!pop && bubble_q != 16'hFFFF) bubble_d = bubble_q + 16'd1;
`endif
                if (pop && mem_last_q[rd_ptr_q]) begin
                    if (ROWS == 1) begin
                        state_d     = S_IDLE;
                        done_d      = 1'b1;
                        last_seen_d = 1'b0;
                    end else begin
                        // Counter counts down to zero, giving ROWS-1 DRAIN cycles.
                        state_d     = S_DRAIN;
                        drain_cnt_d = CW'(ROWS - 2);
                    end
                end
            end
            S_DRAIN: begin
                if (drain_cnt_q == '0) begin
                    state_d     = S_IDLE;
                    done_d      = 1'b1;
                    last_seen_d = 1'b0;
                end else begin
                    drain_cnt_d = drain_cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        pe_mode_d  = (state_d != S_IDLE) ? PEMODE_PS : PEMODE_WL;
        busy_d     = (state_d != S_IDLE);
        // Registered ready is computed from next-cycle occupancy, so it never admits a push into a full FIFO.
        in_ready_d = (count_d != (AW+1)'(FIFO_DEPTH)) && (state_d != S_DRAIN) && !last_seen_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            mem_data_q  <= '{default: '0};
            mem_last_q  <= '{default: 1'b0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            drain_cnt_q <= '0;
            last_seen_q <= 1'b0;
            in_ready_q  <= 1'b0;
            pe_mode_q   <= PEMODE_WL;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef FEEDER_BUBBLE_COUNT_EN
            bubble_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            mem_data_q  <= mem_data_d;
            mem_last_q  <= mem_last_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            drain_cnt_q <= drain_cnt_d;
            last_seen_q <= last_seen_d;
            in_ready_q  <= in_ready_d;
            pe_mode_q   <= pe_mode_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef FEEDER_BUBBLE_COUNT_EN
            bubble_q    <= bubble_d;
`endif
        end
    end

    // Row r is a chain of r+1 element registers; the oldest entry sits in the top slice.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [EW*(r+1)-1:0] chain_q, chain_d;
        if (r == 0) begin : g_first
            always_comb chain_d = stage_in[EW-1:0];
        end else begin : g_rest
            always_comb chain_d = {chain_q[EW*r-1:0], stage_in[r*EW +: EW]};
        end
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) chain_q <= '0;
            else          chain_q <= chain_d;
        end
        assign a_out[r*EW +: EW] = chain_q[EW*(r+1)-1 -: EW];
    end

    assign in_if.in_ready = in_ready_q;
    assign pe_mode        = pe_mode_q;
    assign busy           = busy_q;
    assign done           = done_q;
`ifdef FEEDER_BUBBLE_COUNT_EN
    assign bubble_count   = bubble_q;
`endif
endmodule
